// File: rtl/data_mem_responder.sv
// Word-organised data-memory responder with a req/ack handshake, programmable wait states
// and misaligned/out-of-range error reporting. Define DMEM_BYTE_LANE_EN for byte-lane stores.
`timescale 1ns/1ps

module data_mem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN     = 33'd4 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH];

  logic                  resp_entry_s;
  logic                  acc_we_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [3:0]            acc_be_s;
  logic [31:0]           acc_off_s;
  logic [DEPTH_LOG2-1:0] acc_idx_s;
  logic                  acc_err_s;
  logic [3:0]            lane_en_s;
  logic                  mem_we_s;

`ifdef DMEM_BYTE_LANE_EN
  // Alignment depends on access size: single bytes anywhere, halfwords even, words on 4.
  function automatic logic misaligned(input logic [1:0] low, input logic [3:0] lanes);
    logic bad;
    case (lanes)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
      4'b0011, 4'b1100:                            bad = low[0];
      4'b1111:                                     bad = (low != 2'b00);
      default:                                     bad = 1'b1;
    endcase
    return bad;
  endfunction
  assign lane_en_s = acc_be_s;
`else
  function automatic logic misaligned(input logic [1:0] low);
    return (low != 2'b00);
  endfunction
  logic unused_be_s;
  assign unused_be_s = ^acc_be_s;
  assign lane_en_s   = 4'b1111;
`endif

  // A zero-wait access completes straight from IDLE, so it must see the live inputs.
  assign acc_we_s    = (state_q == S_IDLE) ? we    : we_q;
  assign acc_addr_s  = (state_q == S_IDLE) ? addr  : addr_q;
  assign acc_wdata_s = (state_q == S_IDLE) ? wdata : wdata_q;
  assign acc_be_s    = (state_q == S_IDLE) ? be    : be_q;
  assign acc_off_s   = acc_addr_s - BASE_ADDR;
  assign acc_idx_s   = acc_off_s[DEPTH_LOG2+1:2];

`ifdef DMEM_BYTE_LANE_EN
  assign acc_err_s = ({1'b0, acc_off_s} >= SPAN) | misaligned(acc_addr_s[1:0], acc_be_s);
`else
  assign acc_err_s = ({1'b0, acc_off_s} >= SPAN) | misaligned(acc_addr_s[1:0]);
`endif

  assign mem_we_s = resp_entry_s & acc_we_s & ~acc_err_s & ~rst;

  // Next-state, request capture and response data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_entry_s = 1'b0;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d      = S_RESP;
            resp_entry_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d      = S_RESP;
          resp_entry_s = 1'b1;
          cnt_d        = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (resp_entry_s) begin
      ack_d = 1'b1;
      err_d = acc_err_s;
      if (!acc_err_s && !acc_we_s) begin
        rdata_d = mem[acc_idx_s];
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      ack_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'b0000;
      rdata_q <= 32'h0000_0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en_s[i]) begin
          mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
